// File: rtl/g16_inv_pipe.sv
// Three-stage GF(2^4) inverter, tower/normal basis (Z^4, Z) over GF(2^2) (W^2, W),
// with a valid/ready handshake on both sides and an opaque tag carried per datum.
module g16_inv_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf4_sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] gf4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [1:0]       a1_q, a1_d, b1_q, b1_d, c1_q, c1_d;
  logic [1:0]       a2_q, a2_d, b2_q, b2_d, d2_q, d2_d;
  logic [1:0]       p3_q, p3_d, q3_q, q3_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [1:0]       occ_q, occ_d;
  logic             adv1, adv2, adv3;
  logic             load1, load2, load3;
  logic [1:0]       a_in, b_in;

  // Ready chain, per-stage load enables and next-state datapath.
  always_comb begin
    adv3  = ~v3_q | out_ready;
    adv2  = ~v2_q | adv3;
    adv1  = ~v1_q | adv2;
    load1 = adv1 & in_valid;
    load2 = adv2 & v1_q;
    load3 = adv3 & v2_q;
    a_in  = in_data[3:2];
    b_in  = in_data[1:0];

    v1_d   = adv1 ? in_valid : v1_q;
    a1_d   = load1 ? a_in : a1_q;
    b1_d   = load1 ? b_in : b1_q;
    c1_d   = load1 ? (gf4_scl_n(gf4_sq(a_in ^ b_in)) ^ gf4_mul(a_in, b_in)) : c1_q;
    tag1_d = load1 ? in_tag : tag1_q;

    // Squaring in GF(4) is also the inverse, and maps 0 to 0.
    v2_d   = adv2 ? v1_q : v2_q;
    a2_d   = load2 ? a1_q : a2_q;
    b2_d   = load2 ? b1_q : b2_q;
    d2_d   = load2 ? gf4_sq(c1_q) : d2_q;
    tag2_d = load2 ? tag1_q : tag2_q;

    v3_d   = adv3 ? v2_q : v3_q;
    p3_d   = load3 ? gf4_mul(d2_q, b2_q) : p3_q;
    q3_d   = load3 ? gf4_mul(d2_q, a2_q) : q3_q;
    tag3_d = load3 ? tag2_q : tag3_q;

    occ_d  = {1'b0, v1_d} + {1'b0, v2_d} + {1'b0, v3_d};
  end

  // Pipeline state; reset flushes all in-flight transactions and clears data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= 2'b00;
      b1_q   <= 2'b00;
      c1_q   <= 2'b00;
      a2_q   <= 2'b00;
      b2_q   <= 2'b00;
      d2_q   <= 2'b00;
      p3_q   <= 2'b00;
      q3_q   <= 2'b00;
      tag1_q <= {TAG_W{1'b0}};
      tag2_q <= {TAG_W{1'b0}};
      tag3_q <= {TAG_W{1'b0}};
      occ_q  <= 2'b00;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      c1_q   <= c1_d;
      a2_q   <= a2_d;
      b2_q   <= b2_d;
      d2_q   <= d2_d;
      p3_q   <= p3_d;
      q3_q   <= q3_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      tag3_q <= tag3_d;
      occ_q  <= occ_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = v3_q;
  assign out_data  = {p3_q, q3_q};
  assign out_tag   = tag3_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_g16_inv_pipe.sv
// Self-checking bench for g16_inv_pipe: hand-computed inverse table, directed
// handshake/reset sequences, and a randomized stream against a GF(16) scoreboard.
module tb_g16_inv_pipe;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]       in_data, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [1:0]       occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  g16_inv_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [3:0]       d;
    logic [TAG_W-1:0] t;
  } item_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] inv;
  } vec_t;

  item_t exp_q[$];
  item_t obs_q[$];
  logic  hold_prev;
  item_t hold_item;
  logic  last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // GF(4) multiply done in polynomial basis (W^2 = W + 1), independent of the DUT formula.
  function automatic logic [1:0] m_gf4_mul(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] px, py, pr;
    logic [2:0] prod;
    px = {x[1] ^ x[0], x[1]};
    py = {y[1] ^ y[0], y[1]};
    prod[0] = px[0] & py[0];
    prod[1] = (px[1] & py[0]) ^ (px[0] & py[1]);
    prod[2] = px[1] & py[1];
    pr = {prod[1] ^ prod[2], prod[0] ^ prod[2]};
    return {pr[0], pr[1] ^ pr[0]};
  endfunction

  // GF(16) multiply: Z, Z^4 roots of t^2 + t + N with N = W^2; unity is 4'hF.
  function automatic logic [3:0] m_mul16(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] k;
    k = m_gf4_mul(m_gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]), 2'b10);
    return {m_gf4_mul(x[3:2], y[3:2]) ^ k, m_gf4_mul(x[1:0], y[1:0]) ^ k};
  endfunction

  function automatic logic [3:0] m_inv(input logic [3:0] x);
    for (int y = 1; y < 16; y++) begin
      if (m_mul16(x, 4'(y)) == 4'hF) return 4'(y);
    end
    return 4'h0;
  endfunction

  // One clock: monitor at the falling edge, then return just after the rising edge.
  task automatic cycle();
    item_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {24'd0, out_tag, out_data}, {24'd0, hold_item.t, hold_item.d});
      end
      if (out_valid && out_ready) begin
        obs_q.push_back('{d: out_data, t: out_tag});
        if (exp_q.size() == 0) begin
          check("sb_spurious", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", {28'd0, out_data}, {28'd0, e.d});
          check("sb_tag", {28'd0, out_tag}, {28'd0, e.t});
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{d: m_inv(in_data), t: in_tag});
      hold_prev = out_valid & ~out_ready;
      hold_item = '{d: out_data, t: out_tag};
    end
    last_acc = in_valid & in_ready;
    @(posedge clk);
    #1;
  endtask

  vec_t       vt[16];
  logic [3:0] b2b_in[3];
  logic [3:0] b2b_out[3];
  logic [3:0] snap;
  item_t      first_pass[$];
  int         n, sent, issued, base;

  initial begin
    vt[0]  = '{4'h0, 4'h0}; vt[1]  = '{4'h1, 4'hC}; vt[2]  = '{4'h2, 4'h8}; vt[3]  = '{4'h3, 4'h4};
    vt[4]  = '{4'h4, 4'h3}; vt[5]  = '{4'h5, 4'hA}; vt[6]  = '{4'h6, 4'h7}; vt[7]  = '{4'h7, 4'h6};
    vt[8]  = '{4'h8, 4'h2}; vt[9]  = '{4'h9, 4'hD}; vt[10] = '{4'hA, 4'h5}; vt[11] = '{4'hB, 4'hE};
    vt[12] = '{4'hC, 4'h1}; vt[13] = '{4'hD, 4'h9}; vt[14] = '{4'hE, 4'hB}; vt[15] = '{4'hF, 4'hF};
    b2b_in  = '{4'h3, 4'h4, 4'h0};
    b2b_out = '{4'h4, 4'h3, 4'h0};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_tag = 4'h0; out_ready = 1'b1;
    hold_prev = 1'b0; last_acc = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_occ", {30'd0, occupancy}, 32'd0);
    check("rst_data", {28'd0, out_data}, 32'd0);
    check("rst_tag", {28'd0, out_tag}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single datum: latency 3, occupancy 1,1,1 then 0.
    in_valid = 1'b1; in_data = 4'hF; in_tag = 4'h1;
    cycle();
    check("single_acc", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0; in_data = 4'h5;
    for (int k = 1; k <= 3; k++) begin
      check("single_occ", {30'd0, occupancy}, 32'd1);
      check("single_valid", {31'd0, out_valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) cycle();
    end
    check("single_data", {28'd0, out_data}, 32'hF);
    check("single_tag", {28'd0, out_tag}, 32'd1);
    cycle();
    check("single_occ_end", {30'd0, occupancy}, 32'd0);
    check("single_valid_end", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream, outputs on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = b2b_in[i]; in_tag = 4'(i);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_data", {28'd0, out_data}, {28'd0, b2b_out[i]});
      check("b2b_tag", {28'd0, out_tag}, 32'(i));
      cycle();
    end
    check("b2b_empty", {31'd0, out_valid}, 32'd0);

    // Table sweep of all 16 inputs, then feed the results back.
    obs_q.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = vt[i].x; in_tag = 4'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("tbl_count", 32'(obs_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      check("tbl_inv", {28'd0, obs_q[i].d}, {28'd0, vt[i].inv});
      check("tbl_tag", {28'd0, obs_q[i].t}, 32'(i));
      if (vt[i].x != 4'h0) check("tbl_prod", {28'd0, m_mul16(vt[i].x, obs_q[i].d)}, 32'hF);
    end
    first_pass = obs_q;
    obs_q.delete();
    foreach (first_pass[i]) begin
      in_valid = 1'b1; in_data = first_pass[i].d; in_tag = first_pass[i].t;
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("dbl_count", 32'(obs_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      check("dbl_inv", {28'd0, obs_q[i].d}, {28'd0, vt[i].x});
    end

    // Fill with out_ready low, then a single simultaneous retire + accept.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 5); in_tag = 4'(i + 4);
      cycle();
      check("fill_acc", {31'd0, last_acc}, 32'd1);
    end
    check("fill_occ", {30'd0, occupancy}, 32'd3);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    check("fill_valid", {31'd0, out_valid}, 32'd1);
    in_data = 4'h9; in_tag = 4'h9;
    snap = out_data;
    cycle();
    check("stall_acc", {31'd0, last_acc}, 32'd0);
    check("stall_data", {28'd0, out_data}, {28'd0, snap});
    check("stall_occ", {30'd0, occupancy}, 32'd3);
    base = obs_q.size();
    out_ready = 1'b1;
    cycle();
    check("swap_acc", {31'd0, last_acc}, 32'd1);
    check("swap_retire", 32'(obs_q.size()), 32'(base + 1));
    check("swap_occ", {30'd0, occupancy}, 32'd3);
    out_ready = 1'b0; in_valid = 1'b0;
    cycle();
    check("swap_hold_occ", {30'd0, occupancy}, 32'd3);
    out_ready = 1'b1;
    repeat (5) cycle();
    check("swap_drain_occ", {30'd0, occupancy}, 32'd0);

    // Randomized traffic with 50% valid/ready.
    obs_q.delete();
    sent = 0; issued = 0; n = 0; in_valid = 1'b0; last_acc = 1'b0;
    while (sent < 2000 && n < 20000) begin
      if (!in_valid || last_acc) begin
        if (issued < 2000 && ($urandom % 2) == 0) begin
          in_valid = 1'b1; in_data = 4'($urandom); in_tag = TAG_W'(issued);
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom % 2);
      cycle();
      n++;
      if (in_valid && last_acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    check("rand_sent", 32'(sent), 32'd2000);
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(obs_q.size()), 32'd2000);

    // Reset with two items in flight: nothing from them may emerge.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 1); in_tag = 4'(i + 10);
      cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_occ", {30'd0, occupancy}, 32'd2);
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    check("mid_rst_data", {28'd0, out_data}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    base = obs_q.size();
    repeat (6) cycle();
    check("flush_none", 32'(obs_q.size()), 32'(base));
    check("flush_occ", {30'd0, occupancy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/g16_inv_pipe.md
Name: g16_inv_pipe

Overview:
- 3-stage pipelined inverter in GF(2^4), tower/normal basis (Z^4, Z) over GF(2^2) normal basis (W^2, W).
- Built from GF(2^2) multiply, square and scale-by-N sub-functions.
- Sits in the S-box datapath between the GF(2^8)→GF(2^4) reduction stage (upstream) and the GF(2^4) output-multiply stage (downstream).
- Valid/ready handshake on both sides; carries an opaque sideband tag so callers can track lanes/rounds.

Parameters:
TAG_W, 4, width of sideband tag carried alongside each datum (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream presents a datum
in_ready  output  1  block accepts datum this cycle
in_data  input  4  x = {A[1:0], B[1:0]}, A = Z^4 coefficient, B = Z coefficient
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_data  output  4  x^-1 = {p[1:0], q[1:0]}
out_tag  output  TAG_W  tag of the same transaction
occupancy  output  2  number of valid stages (0..3)

Behaviour:
- GF(2^2) ops on v = {a,b}:
  - mul(x,y): e = (a^b)&(c^d); z = {(a&c)^e, (b&d)^e}.
  - sq(v) = {b,a} (also the GF(4) inverse).
  - scl_N(v) = {b, a^b}.
- Stage 1 registers: c = scl_N(sq(A^B)) ^ mul(A,B), plus A, B, tag.
- Stage 2 registers: d = sq(c), plus A, B, tag.
- Stage 3 registers: p = mul(d,B), q = mul(d,A), plus tag; drives out_data = {p,q}.
- Inverse of 0 is 0 by construction; no special case.
- Each stage k has valid bit vk. Advance condition: adv3 = ~v3 | out_ready; adv2 = ~v2 | adv3; adv1 = ~v1 | adv2; in_ready = adv1.
  - Ready chain is combinational; no combinational path from in_valid to out_valid.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - out_valid = v3.
  - out_data/out_tag held stable while out_valid & ~out_ready.
  - Upstream must not drop or change in_valid/in_data before acceptance (bench asserts).
- Stage k loads from stage k-1 when advk. vk <= v(k-1) (v0 = in_valid) on advance; otherwise holds.
  - Data registers load only when advk & v(k-1), so idle bubbles do not toggle data.
- Latency: 3 cycles from accepted input to out_valid with out_ready held high. Throughput 1/cycle.
- Full pipe (v1=v2=v3=1) with out_ready=0: in_ready=0, all stages hold.
- Full pipe with out_ready=1: simultaneous accept and retire, occupancy stays 3.
- occupancy = v1+v2+v3, registered-state derived.
- Reset:
  - rst=1 clears v1..v3 on that edge; out_valid=0, occupancy=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Data/tag registers also reset to 0; out_data=0, out_tag=0.
  - Reset mid-operation discards all in-flight transactions; none are emitted afterwards.
- No X propagation on outputs after reset, independent of in_data when in_valid=0.

Test Plan:
- Reset then single in_data=4'hF, tag=1, out_ready=1 -> out_valid exactly 3 cycles later, out_data=4'hF, out_tag=1; occupancy 1,1,1 then 0.
- Back-to-back 4'h3, 4'h4, 4'h0, tags 0..2, out_ready=1 -> outputs 4'h4, 4'h3, 4'h0 on consecutive cycles, tags in order.
- Exhaustive sweep 0..15 streamed -> inv(inv(x))==x for all x; x*inv(x)==4'hF for x!=0 via bench model; inv(0)=0.
- Fill 3 items with out_ready=0 -> occupancy=3, in_ready=0, out_data stable; release out_ready for 1 cycle while in_valid=1 -> exactly one retire and one accept, occupancy stays 3.
- Random in_valid/out_ready (50%) over 2000 items -> scoreboard matches in order, no loss or duplication, handshake stability assertions pass.
- rst asserted with 2 items in flight -> next cycle out_valid=0, occupancy=0, out_data=0; flushed items never appear.
